// File: rtl/except_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : except_commit_arbiter
// Purpose  : Writeback exception merge. An older exception carried down the
//            pipeline beats the N_SRC new sources, and the lowest source index
//            wins among the new ones. The winner is held in a trap register
//            until the trap unit acknowledges it. The block also keeps a
//            saturating trap counter and a sticky overlap flag.
// Revision : 1.0 - initial release
// ============================================================================
module except_commit_arbiter #(
   parameter int XLEN  = 64,
   parameter int N_SRC = 4,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  valid_wb,
   input  logic [XLEN-1:0]       pc_wb,
   input  logic                  except_in_valid,
   input  logic [XLEN-1:0]       except_in_epc,
   input  logic [XLEN-1:0]       except_in_cause,
   input  logic [XLEN-1:0]       except_in_tval,
   input  logic [N_SRC-1:0]      src_valid,
   input  logic [N_SRC*XLEN-1:0] src_cause,
   input  logic [N_SRC*XLEN-1:0] src_tval,
   input  logic                  trap_ack,
   output logic                  except_happen_wb,
   output logic                  trap_valid,
   output logic [XLEN-1:0]       trap_epc,
   output logic [XLEN-1:0]       trap_cause,
   output logic [XLEN-1:0]       trap_tval,
   output logic                  stall_req,
   output logic [CNT_W-1:0]      exc_count,
   output logic                  err_overlap
);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   state_t             state_q;
   logic               trap_valid_q;
   logic [XLEN-1:0]    trap_epc_q;
   logic [XLEN-1:0]    trap_cause_q;
   logic [XLEN-1:0]    trap_tval_q;
   logic [CNT_W-1:0]   exc_count_q;
   logic               err_overlap_q;

   logic               w_src_any;
   logic [XLEN-1:0]    w_src_cause;
   logic [XLEN-1:0]    w_src_tval;
   logic               cand_valid_d;
   logic [XLEN-1:0]    cand_epc_d;
   logic [XLEN-1:0]    cand_cause_d;
   logic [XLEN-1:0]    cand_tval_d;

   // Pick the lowest-index active source; scanning downward lets index 0 win.
   always_comb begin
      w_src_any   = |src_valid;
      w_src_cause = '0;
      w_src_tval  = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (src_valid[i]) begin
            w_src_cause = src_cause[i*XLEN +: XLEN];
            w_src_tval  = src_tval[i*XLEN +: XLEN];
         end
      end
   end

   // Merge: the older exception always wins. New sources count only when the slot is valid.
   always_comb begin
      cand_valid_d = except_in_valid | (valid_wb & w_src_any);
      cand_epc_d   = except_in_valid ? except_in_epc   : pc_wb;
      cand_cause_d = except_in_valid ? except_in_cause : w_src_cause;
      cand_tval_d  = except_in_valid ? except_in_tval  : w_src_tval;
   end

   // A new exception is reported regardless of trap state; a flush squashes it.
   always_comb begin
      except_happen_wb = valid_wb & w_src_any & ~except_in_valid & ~flush;
   end

   // Trap FSM: capture in IDLE, hold until ack, and flag any candidate that arrives while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         trap_valid_q  <= 1'b0;
         trap_epc_q    <= '0;
         trap_cause_q  <= '0;
         trap_tval_q   <= '0;
         exc_count_q   <= '0;
         err_overlap_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!flush && !stall && cand_valid_d) begin
                  state_q      <= ST_PENDING;
                  trap_valid_q <= 1'b1;
                  trap_epc_q   <= cand_epc_d;
                  trap_cause_q <= cand_cause_d;
                  trap_tval_q  <= cand_tval_d;
                  if (exc_count_q != {CNT_W{1'b1}}) begin
                     exc_count_q <= exc_count_q + 1'b1;
                  end
               end
            end
            ST_PENDING: begin
               if (cand_valid_d) begin
                  err_overlap_q <= 1'b1;
               end
               if (trap_ack) begin
                  state_q      <= ST_IDLE;
                  trap_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               trap_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign trap_valid  = trap_valid_q;
   assign stall_req   = trap_valid_q;
   assign trap_epc    = trap_epc_q;
   assign trap_cause  = trap_cause_q;
   assign trap_tval   = trap_tval_q;
   assign exc_count   = exc_count_q;
   assign err_overlap = err_overlap_q;

endmodule
`default_nettype wire
